// File: rtl/switch_debouncer.sv
// Switch/pushbutton debouncer: synchronises a raw asynchronous input, then only
// changes the debounced level after the new value has held for STABLE_CYCLES cycles.
module switch_debouncer #(
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic settling
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_CYCLES - 1);

    // Encoding chosen so bit 1 is the debounced level and bit 0 marks a WAIT
    // state: both outputs come straight off flops and cannot glitch.
    localparam logic [1:0] ZERO  = 2'b00;
    localparam logic [1:0] WAIT1 = 2'b01;
    localparam logic [1:0] ONE   = 2'b10;
    localparam logic [1:0] WAIT0 = 2'b11;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sw_s;
    logic [1:0]             state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) sync_reg[gi] <= 1'b0;
                    else       sync_reg[gi] <= sw;
                end
            end else begin : g_next
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) sync_reg[gi] <= 1'b0;
                    else       sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign sw_s = sync_reg[SYNC_STAGES-1];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ZERO: begin
                if (sw_s) begin
                    state_next = WAIT1;
                    cnt_next   = CNT_LOAD;
                end
            end
            WAIT1: begin
                if (!sw_s)              state_next = ZERO;
                else if (cnt_reg == '0) state_next = ONE;
                else                    cnt_next   = cnt_reg - CNT_W'(1);
            end
            ONE: begin
                if (!sw_s) begin
                    state_next = WAIT0;
                    cnt_next   = CNT_LOAD;
                end
            end
            WAIT0: begin
                if (sw_s)               state_next = ONE;
                else if (cnt_reg == '0) state_next = ZERO;
                else                    cnt_next   = cnt_reg - CNT_W'(1);
            end
            default: state_next = ZERO;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ZERO;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign db_level = state_reg[1];
    assign settling = state_reg[0];

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: two configurations checked every cycle against a
// run-length model, plus directed scenarios with hand-computed expectations.
module tb_switch_debouncer;

    localparam int STAB [2] = '{4, 1};
    localparam int SYNC [2] = '{2, 3};

    logic       clk = 1'b0;
    logic       reset;
    logic       sw;
    logic [1:0] db;
    logic [1:0] st;
    logic [1:0] lvl_m;
    logic [1:0] set_m;
    logic       armed;
    int         errors;
    int         checks;
    int         ticks = 0;
    logic       last_db0 = 1'b0;
    int         t0;

    always #5 clk = ~clk;

    // Model: the level flips once the synchronised input has differed from it
    // on STABLE_CYCLES+1 consecutive edges; any agreeing edge clears the run.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_inst
            localparam int SC = STAB[gi];
            localparam int SS = SYNC[gi];
            logic [SS-1:0] hist;
            int            run;
            logic          level;

            switch_debouncer #(.STABLE_CYCLES(SC), .SYNC_STAGES(SS)) u_dut (
                .clk      (clk),
                .reset    (reset),
                .sw       (sw),
                .db_level (db[gi]),
                .settling (st[gi])
            );

            always @(posedge clk or posedge reset) begin
                if (reset) begin
                    hist  <= '0;
                    run   <= 0;
                    level <= 1'b0;
                end else begin
                    hist <= {hist[SS-2:0], sw};
                    if (hist[SS-1] != level) begin
                        if (run == SC) begin
                            level <= ~level;
                            run   <= 0;
                        end else begin
                            run <= run + 1;
                        end
                    end else begin
                        run <= 0;
                    end
                end
            end

            assign lvl_m[gi] = level;
            assign set_m[gi] = (run != 0);
        end
    endgenerate

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("model db_level[%0d]", i), db[i], lvl_m[i]);
                chk($sformatf("model settling[%0d]", i), st[i], set_m[i]);
            end
            ticks    <= ticks + ((db[0] && !last_db0) ? 1 : 0);
            last_db0 <= db[0];
        end
    end

    initial begin
        logic [5:0] pat_press;
        logic [5:0] pat_rel;
        pat_press = 6'b101011;   // bit i applied at edge i+1: 1,1,0,1,0,1
        pat_rel   = 6'b010100;   // 0,0,1,0,1,0
        sw = 1'b0; reset = 1'b0; armed = 1'b0; errors = 0; checks = 0;
        #2 reset = 1'b1;
        #3 armed = 1'b1;
        step(3);
        chk("reset db_level", db[0], 1'b0);
        chk("reset settling", st[0], 1'b0);
        reset = 1'b0;
        step(3);

        // clean press
        sw = 1'b1;
        step(2); chk("press settling e2", st[0], 1'b0);
        step(1); chk("press settling e3", st[0], 1'b1);
                 chk("press db e3", db[0], 1'b0);
        step(1); chk("press S1 db e4", db[1], 1'b0);
        step(1); chk("press S1 db e5", db[1], 1'b1);
        step(1); chk("press db e6", db[0], 1'b0);
        step(1); chk("press db e7", db[0], 1'b1);
                 chk("press settling e7", st[0], 1'b0);
        step(3);

        // clean release
        sw = 1'b0;
        step(3); chk("release db e3", db[0], 1'b1);
                 chk("release settling e3", st[0], 1'b1);
        step(3); chk("release db e6", db[0], 1'b1);
                 chk("release settling e6", st[0], 1'b1);
        step(1); chk("release db e7", db[0], 1'b0);
                 chk("release settling e7", st[0], 1'b0);
        step(3);

        // bouncing press: exactly one tick
        t0 = ticks;
        for (int i = 0; i < 6; i++) begin
            sw = pat_press[i];
            step(1);
        end
        step(5); chk("bounce press db e11", db[0], 1'b0);
        step(1); chk("bounce press db e12", db[0], 1'b1);
        step(3); chk("press one tick", (ticks - t0) == 1, 1'b1);

        // bouncing release: no tick
        t0 = ticks;
        for (int i = 0; i < 6; i++) begin
            sw = pat_rel[i];
            step(1);
        end
        step(5); chk("bounce release db e11", db[0], 1'b1);
        step(1); chk("bounce release db e12", db[0], 1'b0);
        step(3); chk("release no tick", (ticks - t0) == 0, 1'b1);

        // short glitch of 4 cycles
        sw = 1'b1;
        step(4);
        sw = 1'b0;
        step(2); chk("glitch settling e6", st[0], 1'b1);
                 chk("glitch db e6", db[0], 1'b0);
        step(1); chk("glitch settling e7", st[0], 1'b0);
                 chk("glitch db e7", db[0], 1'b0);
        step(3);

        // reset while in WAIT1 with cnt=2
        sw = 1'b1;
        step(4); chk("pre-reset settling", st[0], 1'b1);
        #2 reset = 1'b1;
        #1 chk("async reset settling", st[0], 1'b0);
           chk("async reset db", db[0], 1'b0);
           chk("async reset S1 db", db[1], 1'b0);
        step(2);
        reset = 1'b0;
        step(6); chk("post-reset db e6", db[0], 1'b0);
        step(1); chk("post-reset db e7", db[0], 1'b1);
        step(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
